// File: rtl/divider_seq_pkg.sv
// Shared definitions for the sequential divider and its consumers (Hi/Lo register).
// Holds the state encoding, the default operand width and the DivAns field layout.
package divider_seq_pkg;

  localparam int DIV_WIDTH = 32;

  // DivAns = {remainder, quotient}; Hi takes the remainder half, Lo the quotient half
  localparam int DIVANS_W      = 2 * DIV_WIDTH;
  localparam int DIVANS_HI_MSB = 2 * DIV_WIDTH - 1;
  localparam int DIVANS_HI_LSB = DIV_WIDTH;
  localparam int DIVANS_LO_MSB = DIV_WIDTH - 1;
  localparam int DIVANS_LO_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Two-lane conditional two's-complement negate: abs() on the way in,
// sign restoration on the way out.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [1:0][WIDTH-1:0] val,
  input  logic [1:0]            neg,
  output logic [1:0][WIDTH-1:0] res
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign res[gi] = neg[gi] ? ((~val[gi]) + {{(WIDTH-1){1'b0}}, 1'b1}) : val[gi];
  end

endmodule

// File: rtl/divider_seq.sv
// Multicycle radix-2 restoring divider (DIV/DIVU), one quotient bit per clock.
// DivAns is registered and only changes when a result is written or on reset.
module divider_seq
  import divider_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   DividendIn,
  input  logic [WIDTH-1:0]   DivisorIn,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] DivAns
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               signed_reg;
  logic               dvd_neg_reg;
  logic               dvs_neg_reg;
  logic [WIDTH:0]     rem_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH-1:0]   dvs_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [2*WIDTH-1:0] divans_reg;

  logic                  accept;
  logic                  dvd_neg_next;
  logic                  dvs_neg_next;
  logic [1:0][WIDTH-1:0] mag_in;
  logic [1:0][WIDTH-1:0] mag_out;
  logic [1:0]            mag_neg;
  logic [1:0][WIDTH-1:0] fix_in;
  logic [1:0][WIDTH-1:0] fix_out;
  logic [1:0]            fix_neg;
  logic [WIDTH+1:0]      shifted;
  logic [WIDTH+1:0]      trial;
  logic [WIDTH:0]        rem_next;
  logic [WIDTH-1:0]      quo_next;

  assign accept       = Start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign dvd_neg_next = Signed & DividendIn[WIDTH-1];
  assign dvs_neg_next = Signed & DivisorIn[WIDTH-1];

  // Lane 0 = dividend, lane 1 = divisor
  assign mag_in  = {DivisorIn, DividendIn};
  assign mag_neg = {dvs_neg_next, dvd_neg_next};

  div_sign_fix #(.WIDTH(WIDTH)) u_abs_in (
    .val (mag_in),
    .neg (mag_neg),
    .res (mag_out)
  );

  // One restoring step; the extra top bit of the difference acts as the borrow/sign
  assign shifted = {rem_reg, quo_reg[WIDTH-1]};
  assign trial   = shifted - {2'b00, dvs_reg};

  always_comb begin
    rem_next = trial[WIDTH:0];
    quo_next = {quo_reg[WIDTH-2:0], 1'b1};
    if (trial[WIDTH+1]) begin
      rem_next = shifted[WIDTH:0];
      quo_next = {quo_reg[WIDTH-2:0], 1'b0};
    end
  end

  // Lane 0 = quotient, lane 1 = remainder. A zero divisor leaves the all-ones
  // quotient untouched while the remainder still takes the dividend's sign.
  assign fix_in  = {rem_reg[WIDTH-1:0], quo_reg};
  assign fix_neg = {dvd_neg_reg, signed_reg & (dvd_neg_reg ^ dvs_neg_reg) & (|dvs_reg)};

  div_sign_fix #(.WIDTH(WIDTH)) u_sign_out (
    .val (fix_in),
    .neg (fix_neg),
    .res (fix_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      signed_reg  <= 1'b0;
      dvd_neg_reg <= 1'b0;
      dvs_neg_reg <= 1'b0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvs_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      divans_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          done_reg <= 1'b0;
          if (accept) begin
            signed_reg  <= Signed;
            dvd_neg_reg <= dvd_neg_next;
            dvs_neg_reg <= dvs_neg_next;
            quo_reg     <= mag_out[0];
            dvs_reg     <= mag_out[1];
            rem_reg     <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= S_RUN;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_RUN: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg + CNT_ONE;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          divans_reg <= {fix_out[1], fix_out[0]};
          busy_reg   <= 1'b0;
          done_reg   <= 1'b1;
          state_reg  <= S_DONE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy   = busy_reg;
  assign Done   = done_reg;
  assign DivAns = divans_reg;

endmodule
